// File: rtl/fetch_stage.sv
// Instruction-fetch stage: credit-limited in-order imem requests, an address
// FIFO that pairs each response with its PC, and an instruction queue toward
// decode. A redirect flushes the queue and arranges for in-flight responses
// to be discarded as they return.
module fetch_stage #(
  parameter int XLEN     = 32,
  parameter int FQ_DEPTH = 2
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [XLEN-1:0] io_pc,
  input  logic            io_redirect,
  output logic            io_pc_stall,
  output logic            io_imem_req_valid,
  input  logic            io_imem_req_ready,
  output logic [XLEN-1:0] io_imem_req_addr,
  input  logic            io_imem_resp_valid,
  input  logic [XLEN-1:0] io_imem_resp_data,
  output logic            io_id_valid,
  input  logic            io_id_ready,
  output logic [XLEN-1:0] io_id_inst,
  output logic [XLEN-1:0] io_id_pc
);
  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_OCC = FQ_DEPTH[CW:0];

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fq_entry_t;

  cnt_t            inflight_q, inflight_d;
  cnt_t            drop_q, drop_d;
  cnt_t            q_cnt_q, q_cnt_d;
  ptr_t            af_wr_q, af_rd_q;
  ptr_t            fq_wr_q, fq_wr_d, fq_rd_q, fq_rd_d;
  logic [XLEN-1:0] af_mem_q [FQ_DEPTH];
  fq_entry_t       fq_mem_q [FQ_DEPTH];

  logic [CW:0] occ;
  logic        req_fire, enq, deq;

  // Credit: every issued request already owns a queue slot for its response.
  // Gating with reset_n keeps the request and stall outputs at their reset
  // values while reset is held, not just from the next edge.
  always_comb begin
    occ               = {1'b0, inflight_q} + {1'b0, q_cnt_q};
    io_imem_req_valid = reset_n & ~io_redirect & (occ < DEPTH_OCC);
    req_fire          = io_imem_req_valid & io_imem_req_ready;
    io_pc_stall       = ~req_fire;
    io_imem_req_addr  = io_pc;
    io_id_valid       = (q_cnt_q != '0);
    io_id_pc          = fq_mem_q[fq_rd_q].pc;
    io_id_inst        = fq_mem_q[fq_rd_q].inst;
    // Responses during a redirect, or owed to an earlier redirect, are discarded.
    enq               = io_imem_resp_valid & ~io_redirect & (drop_q == '0);
    deq               = io_id_valid & io_id_ready & ~io_redirect;
  end

  // Next-state for counters and queue pointers; a redirect flushes the queue
  // and recomputes how many returning responses are stale.
  always_comb begin
    inflight_d = inflight_q + cnt_t'(req_fire) - cnt_t'(io_imem_resp_valid);
    drop_d     = drop_q;
    q_cnt_d    = q_cnt_q + cnt_t'(enq) - cnt_t'(deq);
    fq_wr_d    = fq_wr_q + ptr_t'(enq);
    fq_rd_d    = fq_rd_q + ptr_t'(deq);
    if (io_redirect) begin
      drop_d  = inflight_q - cnt_t'(io_imem_resp_valid);
      q_cnt_d = '0;
      fq_wr_d = '0;
      fq_rd_d = '0;
    end else if (io_imem_resp_valid && drop_q != '0) begin
      drop_d = drop_q - cnt_t'(1);
    end
  end

  // Control state with asynchronous clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight_q <= '0;
      drop_q     <= '0;
      q_cnt_q    <= '0;
      af_wr_q    <= '0;
      af_rd_q    <= '0;
      fq_wr_q    <= '0;
      fq_rd_q    <= '0;
    end else begin
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      q_cnt_q    <= q_cnt_d;
      af_wr_q    <= af_wr_q + ptr_t'(req_fire);
      af_rd_q    <= af_rd_q + ptr_t'(io_imem_resp_valid);
      fq_wr_q    <= fq_wr_d;
      fq_rd_q    <= fq_rd_d;
    end
  end

  // Storage arrays: contents are only meaningful behind the valid counters.
  always_ff @(posedge clock) begin
    if (req_fire) af_mem_q[af_wr_q] <= io_pc;
    if (enq)      fq_mem_q[fq_wr_q] <= '{pc: af_mem_q[af_rd_q], inst: io_imem_resp_data};
  end

  // A response with nothing outstanding means the memory broke the protocol.
  a_resp_has_req: assert property (@(posedge clock) disable iff (!reset_n)
                                   io_imem_resp_valid |-> (inflight_q != '0));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a PC register model and a fixed-latency
// instruction memory (inst = ~addr) surround the DUT; each task drives one
// scenario and checks hand-derived cycle-exact expectations.
module tb_fetch_stage;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        redirect = 1'b0, req_ready = 1'b0, id_ready = 1'b0;
  logic        pc_set = 1'b0;
  logic [31:0] pc = 32'h0, pc_tgt = 32'h0;
  logic        pc_stall, req_valid, resp_valid, id_valid;
  logic [31:0] req_addr, resp_data, id_inst, id_pc;
  int          lat = 1;
  int          checks = 0, errors = 0;
  int          fire_cnt = 0;
  logic [31:0] got_pc[$];
  logic [31:0] got_inst[$];
  logic        sr_v [1:3];
  logic [31:0] sr_a [1:3];

  always #5 clock = ~clock;

  fetch_stage dut (
    .clock(clock), .reset_n(reset_n), .io_pc(pc), .io_redirect(redirect),
    .io_pc_stall(pc_stall), .io_imem_req_valid(req_valid), .io_imem_req_ready(req_ready),
    .io_imem_req_addr(req_addr), .io_imem_resp_valid(resp_valid), .io_imem_resp_data(resp_data),
    .io_id_valid(id_valid), .io_id_ready(id_ready), .io_id_inst(id_inst), .io_id_pc(id_pc)
  );

  // PC register: load wins, otherwise advance unless held.
  always @(posedge clock) begin
    if (redirect || pc_set) pc <= pc_tgt;
    else if (!pc_stall)     pc <= pc + 32'd4;
  end

  // Instruction memory: response lat cycles after acceptance.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 1; k <= 3; k++) begin sr_v[k] <= 1'b0; sr_a[k] <= 32'h0; end
    end else begin
      sr_v[1] <= req_valid && req_ready;
      sr_a[1] <= req_addr;
      sr_v[2] <= sr_v[1]; sr_a[2] <= sr_a[1];
      sr_v[3] <= sr_v[2]; sr_a[3] <= sr_a[2];
    end
  end
  assign resp_valid = sr_v[lat];
  assign resp_data  = ~sr_a[lat];

  // Decode-side log and request counter.
  always @(posedge clock) begin
    if (reset_n && id_valid && id_ready) begin
      got_pc.push_back(id_pc);
      got_inst.push_back(id_inst);
    end
    if (reset_n && req_valid && req_ready) fire_cnt <= fire_cnt + 1;
  end

  task automatic do_reset(input logic [31:0] start, input int l);
    @(negedge clock);
    reset_n = 1'b0; redirect = 1'b0; req_ready = 1'b0; id_ready = 1'b0;
    lat = l; pc_set = 1'b1; pc_tgt = start;
    @(negedge clock);
    pc_set = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clock); #1;
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", req_valid); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid: got %b expected 0", id_valid); end
    checks++; if (pc_stall !== 1'b1) begin errors++; $display("FAIL reset_pc_stall: got %b expected 1", pc_stall); end
  endtask

  task automatic test_stream;
    int base, f0;
    do_reset(32'h0, 1);
    req_ready = 1'b1; id_ready = 1'b1;
    base = got_pc.size(); f0 = fire_cnt;
    for (int i = 0; i < 15; i++) begin
      #1;
      checks++;
      if (pc_stall !== !(req_valid && req_ready)) begin
        errors++; $display("FAIL stream_stall c%0d: got %b expected %b", i, pc_stall, !(req_valid && req_ready));
      end
      checks++;
      if (pc !== 32'(4 * (fire_cnt - f0))) begin
        errors++; $display("FAIL stream_pc_advance c%0d: got %h expected %h", i, pc, 32'(4 * (fire_cnt - f0)));
      end
      @(negedge clock);
    end
    checks++;
    if (got_pc.size() - base < 8) begin
      errors++; $display("FAIL stream_count: got %0d expected >=8", got_pc.size() - base);
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (got_pc[base+k] !== 32'(4*k) || got_inst[base+k] !== ~32'(4*k)) begin
          errors++; $display("FAIL stream_order #%0d: got pc %h inst %h expected pc %h inst %h",
                             k, got_pc[base+k], got_inst[base+k], 32'(4*k), ~32'(4*k));
        end
      end
    end
  endtask

  task automatic test_backpressure;
    int base, f0;
    do_reset(32'h40, 1);
    req_ready = 1'b1; id_ready = 1'b0; f0 = fire_cnt;
    repeat (6) @(negedge clock);
    #1;
    checks++; if (fire_cnt - f0 !== 2) begin errors++; $display("FAIL bp_fires: got %0d expected 2", fire_cnt - f0); end
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid: got %b expected 0", req_valid); end
    checks++; if (pc_stall !== 1'b1) begin errors++; $display("FAIL bp_pc_stall: got %b expected 1", pc_stall); end
    checks++; if (pc !== 32'h48) begin errors++; $display("FAIL bp_pc: got %h expected 00000048", pc); end
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h40 || id_inst !== ~32'h40) begin
      errors++; $display("FAIL bp_head: got v%b pc %h inst %h expected v1 pc 00000040 inst %h", id_valid, id_pc, id_inst, ~32'h40);
    end
    base = got_pc.size();
    id_ready = 1'b1;
    repeat (20) @(negedge clock);
    checks++;
    if (got_pc.size() - base < 6) begin
      errors++; $display("FAIL bp_resume_count: got %0d expected >=6", got_pc.size() - base);
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (got_pc[base+k] !== 32'h40 + 32'(4*k)) begin
          errors++; $display("FAIL bp_resume_order #%0d: got %h expected %h", k, got_pc[base+k], 32'h40 + 32'(4*k));
        end
      end
    end
  endtask

  task automatic test_imem_stall;
    int base;
    do_reset(32'h100, 1);
    req_ready = 1'b0; id_ready = 1'b1; base = got_pc.size();
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (pc_stall !== 1'b1 || req_addr !== 32'h100 || req_valid !== 1'b1) begin
        errors++; $display("FAIL imem_hold c%0d: got stall %b addr %h valid %b expected 1 00000100 1", i, pc_stall, req_addr, req_valid);
      end
      @(negedge clock);
    end
    req_ready = 1'b1; #1;
    checks++; if (pc_stall !== 1'b0) begin errors++; $display("FAIL imem_accept_stall: got %b expected 0", pc_stall); end
    @(negedge clock);
    req_ready = 1'b0; #1;
    checks++;
    if (pc_stall !== 1'b1 || req_addr !== 32'h104) begin
      errors++; $display("FAIL imem_after_accept: got stall %b addr %h expected 1 00000104", pc_stall, req_addr);
    end
    @(negedge clock);
    req_ready = 1'b1;
    repeat (6) @(negedge clock);
    checks++;
    if (got_pc.size() - base < 2 || got_pc[base] !== 32'h100 || got_pc[base+1] !== 32'h104) begin
      errors++; $display("FAIL imem_delivered: got %0d entries first %h expected 00000100 then 00000104",
                         got_pc.size() - base, (got_pc.size() > base) ? got_pc[base] : 32'hx);
    end
  endtask

  task automatic test_redirect;
    int base, n;
    do_reset(32'h10, 3);
    req_ready = 1'b1; id_ready = 1'b1; base = got_pc.size();
    @(negedge clock);
    @(negedge clock); #1;
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL redir_credit_full: got %b expected 0", req_valid); end
    redirect = 1'b1; pc_tgt = 32'h200; #1;
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL redir_no_req: got %b expected 0", req_valid); end
    @(negedge clock);
    redirect = 1'b0; #1;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL redir_queue_empty: got %b expected 0", id_valid); end
    n = 0;
    while (id_valid !== 1'b1 && n < 20) begin @(negedge clock); #1; n++; end
    checks++; if (n !== 5) begin errors++; $display("FAIL redir_latency: got %0d cycles expected 5", n); end
    checks++;
    if (id_pc !== 32'h200 || id_inst !== ~32'h200 || got_pc.size() !== base) begin
      errors++; $display("FAIL redir_first: got pc %h inst %h delivered %0d expected 00000200 %h 0",
                         id_pc, id_inst, got_pc.size() - base, ~32'h200);
    end
  endtask

  task automatic test_redirect_resp;
    int base, n;
    // Response in the redirect cycle, one more still in flight.
    do_reset(32'h40, 2);
    req_ready = 1'b1; id_ready = 1'b1; base = got_pc.size();
    @(negedge clock);
    @(negedge clock); #1;
    redirect = 1'b1; pc_tgt = 32'h200;
    @(negedge clock);
    redirect = 1'b0; #1;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rr_a_dropped: got %b expected 0", id_valid); end
    checks++;
    if (req_valid !== 1'b1 || req_addr !== 32'h200) begin
      errors++; $display("FAIL rr_a_req: got v%b addr %h expected v1 00000200", req_valid, req_addr);
    end
    n = 0;
    while (id_valid !== 1'b1 && n < 20) begin @(negedge clock); #1; n++; end
    checks++; if (n !== 3) begin errors++; $display("FAIL rr_a_latency: got %0d cycles expected 3", n); end
    checks++;
    if (id_pc !== 32'h200 || got_pc.size() !== base) begin
      errors++; $display("FAIL rr_a_first: got pc %h delivered %0d expected 00000200 0", id_pc, got_pc.size() - base);
    end
    // Response and head dequeue both in the redirect cycle.
    do_reset(32'h40, 2);
    req_ready = 1'b1; id_ready = 1'b1; base = got_pc.size();
    @(negedge clock);
    @(negedge clock);
    @(negedge clock); #1;
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h40) begin
      errors++; $display("FAIL rr_b_head: got v%b pc %h expected v1 00000040", id_valid, id_pc);
    end
    redirect = 1'b1; pc_tgt = 32'h300;
    @(negedge clock);
    redirect = 1'b0; #1;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rr_b_flushed: got %b expected 0", id_valid); end
    checks++;
    if (req_valid !== 1'b1 || req_addr !== 32'h300) begin
      errors++; $display("FAIL rr_b_req: got v%b addr %h expected v1 00000300", req_valid, req_addr);
    end
    n = 0;
    while (id_valid !== 1'b1 && n < 20) begin @(negedge clock); #1; n++; end
    checks++; if (n !== 3) begin errors++; $display("FAIL rr_b_latency: got %0d cycles expected 3", n); end
    checks++;
    if (id_pc !== 32'h300 || got_pc.size() !== base + 1) begin
      errors++; $display("FAIL rr_b_first: got pc %h delivered %0d expected 00000300 1", id_pc, got_pc.size() - base);
    end
  endtask

  task automatic test_back_to_back;
    int base, n;
    do_reset(32'h10, 3);
    req_ready = 1'b1; id_ready = 1'b1; base = got_pc.size();
    @(negedge clock);
    @(negedge clock);
    redirect = 1'b1; pc_tgt = 32'h200;
    @(negedge clock);
    pc_tgt = 32'h300; #1;
    checks++;
    if (req_valid !== 1'b0 || req_addr !== 32'h200) begin
      errors++; $display("FAIL b2b_second: got v%b addr %h expected v0 00000200", req_valid, req_addr);
    end
    @(negedge clock);
    redirect = 1'b0; #1;
    checks++;
    if (id_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'h300) begin
      errors++; $display("FAIL b2b_after: got idv%b reqv%b addr %h expected 0 1 00000300", id_valid, req_valid, req_addr);
    end
    n = 0;
    while (id_valid !== 1'b1 && n < 20) begin @(negedge clock); #1; n++; end
    checks++; if (n !== 4) begin errors++; $display("FAIL b2b_latency: got %0d cycles expected 4", n); end
    checks++;
    if (id_pc !== 32'h300 || got_pc.size() !== base) begin
      errors++; $display("FAIL b2b_first: got pc %h delivered %0d expected 00000300 0", id_pc, got_pc.size() - base);
    end
  endtask

  task automatic test_reset_mid;
    int base, n;
    do_reset(32'h10, 3);
    req_ready = 1'b1; id_ready = 1'b1; base = got_pc.size();
    @(negedge clock);
    @(negedge clock);
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if (req_valid !== 1'b0 || id_valid !== 1'b0 || pc_stall !== 1'b1) begin
      errors++; $display("FAIL mid_reset_outputs: got reqv%b idv%b stall%b expected 0 0 1", req_valid, id_valid, pc_stall);
    end
    @(negedge clock);
    pc_set = 1'b1; pc_tgt = 32'h500;
    @(negedge clock);
    pc_set = 1'b0; #1;
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_held: got %b expected 0", req_valid); end
    @(negedge clock);
    reset_n = 1'b1; #1;
    checks++;
    if (req_valid !== 1'b1 || req_addr !== 32'h500 || pc_stall !== 1'b0) begin
      errors++; $display("FAIL mid_release: got v%b addr %h stall %b expected 1 00000500 0", req_valid, req_addr, pc_stall);
    end
    n = 0;
    while (id_valid !== 1'b1 && n < 20) begin @(negedge clock); #1; n++; end
    checks++; if (n !== 4) begin errors++; $display("FAIL mid_latency: got %0d cycles expected 4", n); end
    checks++;
    if (id_pc !== 32'h500 || id_inst !== ~32'h500 || got_pc.size() !== base) begin
      errors++; $display("FAIL mid_first: got pc %h inst %h delivered %0d expected 00000500 %h 0",
                         id_pc, id_inst, got_pc.size() - base, ~32'h500);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_imem_stall();
    test_redirect();
    test_redirect_resp();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
